// File: rtl/ocext_rr_arbiter_if.sv
// ocext_rr_arbiter_if -- request/grant bundle for ocext_rr_arbiter.
//
// Signals:
//   request        [PORTS]        per-port request level (requester -> arbiter)
//   acknowledge    [PORTS]        per-port release strobe (requester -> arbiter)
//   grant          [PORTS]        one-hot grant (arbiter -> requester)
//   grant_valid                   a grant is held
//   grant_encoded  [$clog2(PORTS)] binary index of the granted port
//   timeout                       one-cycle pulse on watchdog forced release
//
// Modports:
//   master  requester side (drives request/acknowledge)
//   slave   arbiter side (drives the grant outputs)
interface ocext_rr_arbiter_if #(
    parameter int PORTS = 4
);
    localparam int IW = $clog2(PORTS);

    logic [PORTS-1:0] request;
    logic [PORTS-1:0] acknowledge;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [IW-1:0]    grant_encoded;
    logic             timeout;

    modport master (
        output request, acknowledge,
        input  grant, grant_valid, grant_encoded, timeout
    );

    modport slave (
        input  request, acknowledge,
        output grant, grant_valid, grant_encoded, timeout
    );
endinterface

// File: rtl/ocext_rr_arbiter.sv
// ocext_rr_arbiter -- round-robin arbiter with held grants.
//
// A grant is held until the granted port pulses its acknowledge bit, then the
// next requester (searching upward from the last winner, wrapping) is granted
// on the following edge. All outputs are registered, latency 1.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   ocext_rr_arbiter_if.slave (request, acknowledge, grant,
//         grant_valid, grant_encoded, timeout)
//
// Parameters:
//   PORTS    number of requesters (2..64)
//   TIMEOUT  held-grant cycles without acknowledge before forced release
//            (watchdog build only, >= 2)
//
// Build option:
//   OCEXT_RR_ARBITER_WATCHDOG_EN  when defined, a watchdog forces release of a
//   grant held TIMEOUT consecutive cycles without acknowledge and pulses
//   timeout. When undefined, timeout is tied to 0 and grants are held
//   indefinitely until acknowledge.
module ocext_rr_arbiter #(
    parameter int PORTS   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    ocext_rr_arbiter_if.slave bus
);
    localparam int IW = $clog2(PORTS);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PORTS-1:0] grant_q;
    logic [IW-1:0]    enc_q;
    logic [PORTS-1:0] mask_q;

    logic [PORTS-1:0] masked, pool, win_oh, mask_next;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    logic             ack_hit;
    logic             expire;
    logic             arb;

    // Round-robin pick: prefer requesters above the last winner (mask), else
    // wrap to the full request set. pool & ~(pool-1) isolates the lowest set
    // bit; pool==0 yields win_oh==0.
    always_comb begin
        masked  = bus.request & mask_q;
        pool    = (|masked) ? masked : bus.request;
        win_oh  = pool & ~(pool - PORTS'(1));
        win_any = |bus.request;
        win_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (win_oh[i]) win_idx = win_idx | IW'(i);
        end
        // Bits strictly above the winner. For the top port the shift drops
        // out of range, the subtraction wraps to all ones and the mask is 0.
        mask_next = ~((win_oh << 1) - PORTS'(1));
    end

    // enc_q is always a legal port index, so this selects the granted port's
    // acknowledge only; other acknowledge bits never matter.
    assign ack_hit = (state_q == GRANTED) && bus.acknowledge[enc_q];

    always_comb begin
        state_d = state_q;
        arb     = 1'b0;
        case (state_q)
            IDLE: begin
                arb     = 1'b1;
                state_d = win_any ? GRANTED : IDLE;
            end
            GRANTED: begin
                if (ack_hit || expire) begin
                    arb     = 1'b1;
                    state_d = win_any ? GRANTED : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Grant datapath. With no requester win_oh and win_idx are zero, which
    // clears grant and grant_encoded; the mask only moves on a real grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            enc_q   <= '0;
            mask_q  <= '0;
        end else if (arb) begin
            grant_q <= win_oh;
            enc_q   <= win_idx;
            if (win_any) mask_q <= mask_next;
        end
    end

`ifdef OCEXT_RR_ARBITER_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;
    logic          timeout_q;

    // wd_cnt counts completed held cycles of the current grant; expiry fires
    // in the TIMEOUT-th held cycle without acknowledge.
    assign expire = (state_q == GRANTED) && !ack_hit && (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
            if (arb)                       wd_cnt <= '0;
            else if (state_q == GRANTED)   wd_cnt <= wd_cnt + CW'(1);
        end
    end

    assign bus.timeout = timeout_q;
`else
    // No watchdog: never true for a legal TIMEOUT, so grants hold until
    // acknowledge.
    assign expire      = (TIMEOUT < 0);
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant         = grant_q;
    assign bus.grant_encoded = enc_q;
    assign bus.grant_valid   = (state_q == GRANTED);

endmodule

// File: tb/tb_ocext_rr_arbiter.sv
// tb_ocext_rr_arbiter -- directed bench for ocext_rr_arbiter (PORTS=4,
// TIMEOUT=8). A cycle-level model (last-winner pointer plus held-cycle count)
// is compared against the DUT every cycle on the falling edge; literal
// expectations after selected edges pin the model to hand-computed values.
module tb_ocext_rr_arbiter;
    localparam int PORTS   = 4;
    localparam int TIMEOUT = 8;
`ifdef OCEXT_RR_ARBITER_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk;
    logic rst;
    ocext_rr_arbiter_if #(.PORTS(PORTS)) bus ();

    ocext_rr_arbiter #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Search order after a win at 'last': last+1 .. PORTS-1, 0 .. last.
    function automatic int rr_pick(input logic [PORTS-1:0] req, input int last);
        for (int off = 1; off <= PORTS; off++) begin
            int p;
            p = (last + off) % PORTS;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    bit         started = 1'b0;
    bit         m_valid = 1'b0;
    int         m_idx   = 0;
    int         m_last  = PORTS - 1;   // after reset the search starts at port 0
    int         m_held  = 0;           // completed held cycles of this grant
    bit         m_to    = 1'b0;
    bit         m_ack, m_exp, m_arb;
    int         m_pick;
    logic [PORTS-1:0] m_gvec;

    always_comb begin
        m_ack  = m_valid && (bus.acknowledge[m_idx] === 1'b1);
        m_exp  = WD && m_valid && !m_ack && (m_held + 1 == TIMEOUT);
        m_arb  = !m_valid || m_ack || m_exp;
        m_pick = rr_pick(bus.request, m_last);
        m_gvec = m_valid ? PORTS'(1 << m_idx) : '0;
    end

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_last  <= PORTS - 1;
            m_held  <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= m_exp;
            if (m_arb) begin
                m_held <= 0;
                if (m_pick >= 0) begin
                    m_valid <= 1'b1;
                    m_idx   <= m_pick;
                    m_last  <= m_pick;
                end else begin
                    m_valid <= 1'b0;
                    m_idx   <= 0;
                end
            end else begin
                m_held <= m_held + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model grant_valid", 32'(bus.grant_valid), 32'(m_valid));
            chk("model grant", 32'(bus.grant), 32'(m_gvec));
            chk("model grant_encoded", 32'(bus.grant_encoded), 32'(m_idx));
            chk("model timeout", 32'(bus.timeout), 32'(m_to));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [3:0] g, input logic v, input logic [1:0] e, input logic t);
        chk({nm, " grant"}, 32'(bus.grant), 32'(g));
        chk({nm, " valid"}, 32'(bus.grant_valid), 32'(v));
        chk({nm, " enc"}, 32'(bus.grant_encoded), 32'(e));
        chk({nm, " timeout"}, 32'(bus.timeout), 32'(t));
    endtask

    logic [3:0] tbl_req [12] = '{4'b1111, 4'b1111, 4'b0110, 4'b0000, 4'b1000, 4'b1000,
                                 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b1010, 4'b1010};
    logic [3:0] tbl_ack [12] = '{4'b0000, 4'b1111, 4'b0010, 4'b0100, 4'b1111, 4'b0000,
                                 4'b1000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b1111};

    initial begin
        rst             = 1'b1;
        bus.request     = '0;
        bus.acknowledge = '0;
        step();
        step();
        lit("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;

        // basic alternation between ports 0 and 2
        bus.request = 4'b0101;
        step();                                   lit("rr first", 4'b0001, 1'b1, 2'd0, 1'b0);
        bus.acknowledge = 4'b0001; step(); bus.acknowledge = '0;
        lit("rr ack0", 4'b0100, 1'b1, 2'd2, 1'b0);
        bus.acknowledge = 4'b0100; step(); bus.acknowledge = '0;
        lit("rr ack2 wrap", 4'b0001, 1'b1, 2'd0, 1'b0);

        // back-to-back rotation over all ports
        bus.request = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.acknowledge = 4'(1 << i);
            step();
            lit("rotate", 4'(1 << ((i + 1) % 4)), 1'b1, 2'((i + 1) % 4), 1'b0);
        end
        bus.acknowledge = '0;

        // held grant survives request drop and foreign acknowledge
        bus.request = 4'b0010; bus.acknowledge = 4'b0001; step(); bus.acknowledge = '0;
        lit("grant p1", 4'b0010, 1'b1, 2'd1, 1'b0);
        bus.request = 4'b0000; step();           lit("req drop hold", 4'b0010, 1'b1, 2'd1, 1'b0);
        bus.acknowledge = 4'b1000; step();       lit("foreign ack", 4'b0010, 1'b1, 2'd1, 1'b0);
        bus.acknowledge = 4'b0010; step(); bus.acknowledge = '0;
        lit("release idle", 4'b0000, 1'b0, 2'd0, 1'b0);
        bus.acknowledge = 4'b1111; step(); bus.acknowledge = '0;
        lit("idle ack ignored", 4'b0000, 1'b0, 2'd0, 1'b0);

        // sole requester re-grant versus competing requester
        bus.request = 4'b0100; step();           lit("grant p2", 4'b0100, 1'b1, 2'd2, 1'b0);
        bus.acknowledge = 4'b0100; step();       lit("sole regrant", 4'b0100, 1'b1, 2'd2, 1'b0);
        bus.request = 4'b0101; step(); bus.acknowledge = '0;
        lit("compete p0", 4'b0001, 1'b1, 2'd0, 1'b0);

        // reset mid-grant
        bus.request = 4'b1000; bus.acknowledge = 4'b0001; step(); bus.acknowledge = '0;
        lit("grant p3", 4'b1000, 1'b1, 2'd3, 1'b0);
        rst = 1'b1; step();                      lit("mid reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        rst = 1'b0; bus.request = 4'b1001; step();
        lit("post reset", 4'b0001, 1'b1, 2'd0, 1'b0);

        // watchdog: port 0 holds without acknowledge
        bus.request = 4'b0011;
        repeat (7) step();
        lit("wd before", 4'b0001, 1'b1, 2'd0, 1'b0);
        step();
        if (WD) lit("wd expire", 4'b0010, 1'b1, 2'd1, 1'b1);
        else    lit("no wd hold", 4'b0001, 1'b1, 2'd0, 1'b0);
        step();
        if (WD) lit("wd pulse end", 4'b0010, 1'b1, 2'd1, 1'b0);
        else    lit("no wd hold2", 4'b0001, 1'b1, 2'd0, 1'b0);

        // mixed vectors, checked by the model only
        for (int i = 0; i < 12; i++) begin
            bus.request     = tbl_req[i];
            bus.acknowledge = tbl_ack[i];
            step();
        end
        bus.request = '0; bus.acknowledge = '0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
